// File: rtl/uart_cmd_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_cmd_rx : 8N1 UART receiver emitting one-cycle command byte strobes.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Rx,
  output logic [7:0] Cmd,
  output logic       CmdValid,
  output logic       FrameErr,
  output logic       Busy
);

  localparam logic [15:0] c_half_m1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] c_full_m1 = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_rx_meta, r_rx_s, r_rx_d;
  logic [2:0]  r_warm;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [7:0]  r_cmd, w_cmd_nxt;
  logic        r_cmd_valid, w_cmd_valid_nxt;
  logic        r_frame_err, w_frame_err_nxt;
  logic        r_busy, w_busy_nxt;
  logic        w_fall;

  // Reset values of the sync flops are not real line samples; an edge only
  // counts once three genuine samples have flowed in, so a line held low
  // through reset release does not look like a start bit.
  assign w_fall = r_warm[2] & r_rx_d & ~r_rx_s;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_rx_d      <= 1'b1;
      r_warm      <= 3'b000;
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_idx       <= 3'd0;
      r_shift     <= 8'd0;
      r_cmd       <= 8'd0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_meta   <= Rx;
      r_rx_s      <= r_rx_meta;
      r_rx_d      <= r_rx_s;
      r_warm      <= {r_warm[1:0], 1'b1};
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_cmd       <= w_cmd_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + 16'd1;
    w_idx_nxt       = r_idx;
    w_shift_nxt     = r_shift;
    w_cmd_nxt       = 8'd0;
    w_cmd_valid_nxt = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 16'd0;
        if (w_fall) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == c_half_m1) begin
          w_cnt_nxt   = 16'd0;
          w_idx_nxt   = 3'd0;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == c_full_m1) begin
          w_cnt_nxt          = 16'd0;
          w_shift_nxt[r_idx] = r_rx_s;
          w_idx_nxt          = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == c_full_m1) begin
          w_cnt_nxt = 16'd0;
          if (r_rx_s) begin
            w_cmd_nxt       = r_shift;
            w_cmd_valid_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_cnt_nxt = 16'd0;
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign Cmd      = r_cmd;
  assign CmdValid = r_cmd_valid;
  assign FrameErr = r_frame_err;
  assign Busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_cmd_rx : randomized and directed bench for uart_cmd_rx.            |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_uart_cmd_rx;

  localparam int C = 16;
  localparam int H = C / 2;

  logic       Clock;
  logic       Reset_n;
  logic       Rx;
  logic [7:0] Cmd;
  logic       CmdValid;
  logic       FrameErr;
  logic       Busy;

  uart_cmd_rx #(.CLKS_PER_BIT(C)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Rx       (Rx),
    .Cmd      (Cmd),
    .CmdValid (CmdValid),
    .FrameErr (FrameErr),
    .Busy     (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int tests  = 0;
  int failed = 0;

  // Line history: lin[j] is the Rx level driven just after rising edge j.
  int  cyc = 0;
  bit  lin [0:131071];
  int  arm_r0 = 1 << 30;

  always @(posedge Clock) begin
    lin[cyc] = Rx;
    cyc      = cyc + 1;
  end

  // Reference: frames are decoded from the line history at the mid-bit
  // sampling points measured from the detected falling edge.
  bit         m_act = 1'b0;
  bit         m_brk = 1'b0;
  int         m_e   = 0;
  int         rel;
  logic [7:0] e_cmd;
  logic       e_cv, e_fe, e_busy;
  logic [7:0] m_byte;
  int         cv_cyc[$];
  logic [7:0] cv_val[$];
  int         fe_cyc[$];
  int         busy_cnt = 0;

  always @(negedge Clock) begin
    e_cmd = 8'h00; e_cv = 1'b0; e_fe = 1'b0; e_busy = 1'b0;
    if (!Reset_n) begin
      m_act = 1'b0;
      m_brk = 1'b0;
    end else begin
      if (m_act) begin
        rel = cyc - m_e;
        if (m_brk) begin
          if (lin[cyc-3]) m_act = 1'b0;
          else e_busy = 1'b1;
        end else if (rel == 3 + H) begin
          if (lin[m_e+H]) m_act = 1'b0;
          else e_busy = 1'b1;
        end else if (rel == 3 + H + 9 * C) begin
          for (int n = 0; n < 8; n++) m_byte[n] = lin[m_e + H + C * (n + 1)];
          if (lin[m_e + H + 9 * C]) begin
            e_cv  = 1'b1;
            e_cmd = m_byte;
            m_act = 1'b0;
          end else begin
            e_fe   = 1'b1;
            e_busy = 1'b1;
            m_brk  = 1'b1;
          end
        end else begin
          e_busy = 1'b1;
        end
      end
      if (!m_act && (cyc - 3 >= arm_r0) && lin[cyc-3] && !lin[cyc-2]) begin
        m_act = 1'b1;
        m_brk = 1'b0;
        m_e   = cyc - 2;
      end
    end
    tests = tests + 1;
    if (Cmd !== e_cmd || CmdValid !== e_cv || FrameErr !== e_fe || Busy !== e_busy) begin
      failed = failed + 1;
      $display("FAIL model cyc=%0d: got Cmd=%h CmdValid=%b FrameErr=%b Busy=%b, expected Cmd=%h CmdValid=%b FrameErr=%b Busy=%b",
               cyc, Cmd, CmdValid, FrameErr, Busy, e_cmd, e_cv, e_fe, e_busy);
    end
    if (CmdValid === 1'b1) begin
      cv_cyc.push_back(cyc);
      cv_val.push_back(Cmd);
    end
    if (FrameErr === 1'b1) fe_cyc.push_back(cyc);
    if (Busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      failed = failed + 1;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    Rx = v;
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic idle(input int n);
    drive(1'b1, n);
  endtask

  // Bit period in hundredths of a cycle, so skewed baud rates are exact.
  task automatic send(input logic [7:0] b, input logic stop, input int t100);
    logic [9:0] fr;
    int len;
    fr = {stop, b, 1'b0};
    for (int n = 0; n < 10; n++) begin
      len = ((n + 1) * t100 + 50) / 100 - (n * t100 + 50) / 100;
      drive(fr[n], len);
    end
  endtask

  task automatic clear_logs();
    cv_cyc.delete();
    cv_val.delete();
    fe_cyc.delete();
    busy_cnt = 0;
  endtask

  task automatic check_one(input string nm, input logic [7:0] b, input int at);
    check({nm, "_count"}, cv_cyc.size(), 1);
    check({nm, "_ferr"}, fe_cyc.size(), 0);
    if (cv_cyc.size() > 0) begin
      check({nm, "_cmd"}, cv_val[0], b);
      check({nm, "_cyc"}, cv_cyc[0], at);
    end
  endtask

  initial begin
    int k;
    int kind;
    int t100;
    logic [7:0] b;
    logic [9:0] fr;

    Rx = 1'b1;
    Reset_n = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    check("reset_cmd", Cmd, 0);
    check("reset_cv", CmdValid, 0);
    check("reset_fe", FrameErr, 0);
    check("reset_busy", Busy, 0);
    Reset_n = 1'b1;
    arm_r0 = cyc;
    idle(10);

    // Single byte
    clear_logs();
    k = cyc;
    send(8'h52, 1'b1, 1600);
    idle(20);
    check_one("single", 8'h52, k + 155);
    check("single_busy_cycles", busy_cnt, 152);

    // Back-to-back frames
    clear_logs();
    k = cyc;
    send(8'h47, 1'b1, 1600);
    send(8'h42, 1'b1, 1600);
    send(8'h00, 1'b1, 1600);
    idle(20);
    check("b2b_count", cv_cyc.size(), 3);
    if (cv_cyc.size() == 3) begin
      check("b2b_cmd0", cv_val[0], 8'h47);
      check("b2b_cmd1", cv_val[1], 8'h42);
      check("b2b_cmd2", cv_val[2], 8'h00);
      check("b2b_cyc0", cv_cyc[0], k + 155);
      check("b2b_gap1", cv_cyc[1] - cv_cyc[0], 160);
      check("b2b_gap2", cv_cyc[2] - cv_cyc[1], 160);
    end

    // Start glitch
    clear_logs();
    drive(1'b0, 4);
    idle(20);
    check("glitch_cv", cv_cyc.size(), 0);
    check("glitch_busy_cycles", busy_cnt, H);
    check("glitch_busy_end", Busy, 0);

    // Framing error then break
    clear_logs();
    k = cyc;
    send(8'h52, 1'b0, 1600);
    drive(1'b0, 100);
    idle(20);
    check("ferr_count", fe_cyc.size(), 1);
    if (fe_cyc.size() > 0) check("ferr_cyc", fe_cyc[0], k + 155);
    check("ferr_cv", cv_cyc.size(), 0);
    check("ferr_busy_cycles", busy_cnt, 260);
    clear_logs();
    k = cyc;
    send(8'h42, 1'b1, 1600);
    idle(20);
    check_one("after_break", 8'h42, k + 155);

    // Reset during data bit 4 of 0x47
    fr = {1'b1, 8'h47, 1'b0};
    for (int n = 0; n < 5; n++) drive(fr[n], C);
    drive(fr[5], 8);
    check("midframe_busy", Busy, 1);
    Reset_n = 1'b0;
    arm_r0 = 1 << 30;
    #1;
    check("arst_cmd", Cmd, 0);
    check("arst_cv", CmdValid, 0);
    check("arst_fe", FrameErr, 0);
    check("arst_busy", Busy, 0);
    repeat (3) @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    arm_r0 = cyc;
    drive(1'b0, 5);
    idle(30);
    clear_logs();
    k = cyc;
    send(8'h52, 1'b1, 1600);
    idle(20);
    check_one("post_reset", 8'h52, k + 155);

    // Baud skew
    clear_logs();
    k = cyc;
    send(8'hA5, 1'b1, 1664);
    idle(20);
    check_one("skew_slow", 8'hA5, k + 155);
    clear_logs();
    k = cyc;
    send(8'hA5, 1'b1, 1536);
    idle(20);
    check_one("skew_fast", 8'hA5, k + 155);

    // Randomized traffic against the line-level model
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      t100 = $urandom_range(1540, 1660);
      b    = 8'($urandom);
      if (kind == 0) begin
        drive(1'b0, $urandom_range(1, 6));
        idle(14);
      end else if (kind == 1) begin
        send(b, 1'b0, t100);
        drive(1'b0, $urandom_range(0, 40));
        idle($urandom_range(1, 20));
      end else begin
        send(b, 1'b1, t100);
        idle($urandom_range(0, 25));
      end
    end
    idle(200);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

UART receive front end that turns the serial host link into the single-cycle command byte stream consumed by the RGB LED state machine. It deserialises 8N1 frames from the asynchronous `Rx` pin and presents each good byte on `Cmd` for exactly one `Clock` cycle. `Cmd` reads 0x00 at all other times, so a held byte never re-triggers the downstream toggle FSM. It sits between the board RX pad and the `Cmd` input of the LED controller.

## Interface
- `CLKS_PER_BIT`, default 868, `Clock` cycles per UART bit (100 MHz / 115200). Legal range 8..65535.
- `Clock` input 1 — system clock; all logic on rising edge.
- `Reset_n` input 1 — asynchronous, active-low reset; deassertion is synchronous to `Clock` at top level.
- `Rx` input 1 — raw serial line, idle high, asynchronous to `Clock`.
- `Cmd` output 8 — received byte during the `CmdValid` cycle, 0x00 otherwise.
- `CmdValid` output 1 — one-cycle strobe marking a good frame.
- `FrameErr` output 1 — one-cycle strobe when the stop bit samples low.
- `Busy` output 1 — high from start-edge detection until return to IDLE.

## Operation
- `Rx` passes through a 2-flop synchroniser, reset value 1. All decisions use the second flop (`rx_s`). One extra history flop provides falling-edge detection.
- Bit counter is 16 bits wide; bit index is 3 bits; shift register is 8 bits, filled LSB first.
- States:
  - **IDLE**: wait for an `rx_s` falling edge → START, counter = 0.
  - **START**: at counter == CLKS_PER_BIT/2 − 1 (integer division), sample `rx_s`. If 1 → IDLE (glitch rejected, no strobe). If 0 → DATA, counter = 0, index = 0.
  - **DATA**: at counter == CLKS_PER_BIT − 1, shift `rx_s` into bit [index] and clear counter. After index 7 → STOP.
  - **STOP**: at counter == CLKS_PER_BIT − 1, sample `rx_s`.
    - If 1: load `Cmd` with the shift register, assert `CmdValid` next cycle, → IDLE.
    - If 0: assert `FrameErr` next cycle, `Cmd` stays 0x00, → BREAK.
  - **BREAK**: wait until `rx_s` == 1 → IDLE. This stops a held-low line (break) from being read as repeated frames.
- Outputs are registered:
  - `Cmd` and `CmdValid` return to 0x00/0 on the cycle after the strobe.
  - `FrameErr` and `CmdValid` are never both high.
  - A received 0x00 still asserts `CmdValid` with `Cmd` = 0x00.
- No byte filtering; the downstream FSM ignores bytes other than 0x52/0x47/0x42.
- No buffering. A new start edge is accepted only in IDLE. Because IDLE is re-entered mid-stop-bit, back-to-back frames with a single stop bit are received without loss.
- Reset values (asynchronous, on `Reset_n` low):
  - `Cmd` = 0x00, `CmdValid` = 0, `FrameErr` = 0, `Busy` = 0.
  - State = IDLE, synchroniser/history flops = 1, counter/index/shift = 0.
- Reset mid-frame aborts the frame with no strobe. After release, the block waits for the next falling edge; if `Rx` is low at release, no edge is seen until it rises and falls again.

## Timing
- Input latency: 2 cycles of synchroniser plus 1 cycle of edge detect.
- Sampling points, measured in cycles after the edge-detect cycle:
  - start bit: CLKS_PER_BIT/2
  - data bit n: CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT
  - stop bit: CLKS_PER_BIT/2 + 9·CLKS_PER_BIT
- `CmdValid`/`FrameErr` rise 1 cycle after the stop sample and stay high exactly 1 cycle.
- `Busy` rises the cycle after the edge is detected and falls with the strobe cycle (good frame) or on BREAK exit.
- Baud tolerance: ±4% total mismatch with mid-bit sampling.
- Throughput: 1 byte per 10 bit times; at most one `CmdValid` per frame.

## Test plan
- **Single byte.** CLKS_PER_BIT=16; send 0x52 ('R') 8N1 → exactly one cycle with `CmdValid`=1 and `Cmd`=0x52, `Cmd`=0x00 before and after, `FrameErr` never high.
- **Back-to-back frames.** Send 0x47, 0x42, 0x00 with no idle gap → three strobes, `Cmd` = 0x47, 0x42, 0x00 in order, strobes 160 cycles apart.
- **Start glitch.** Drive `Rx` low for 4 cycles, then high → no strobe; `Busy` pulses, then returns to 0 by cycle 8 + latency.
- **Framing error and break.** Send 0x52 with stop bit 0, then hold `Rx` low for 100 cycles → one `FrameErr` pulse, no `CmdValid`, `Cmd` stays 0x00. A subsequent good 0x42 after `Rx` returns high → `Cmd`=0x42 strobe.
- **Reset mid-frame.** Pull `Reset_n` low during data bit 4 of 0x47 → outputs are 0 immediately (asynchronous). After release, send 0x52 → single strobe with 0x52 and no residue from the aborted frame.
- **Baud skew.** Transmit 0xA5 at 104% and at 96% of the nominal bit time (CLKS_PER_BIT=16) → `Cmd`=0xA5 strobe in both cases.
